// File: rtl/ir_pkg.sv
// Shared types and constants for the instruction register assembler and its decoder.
package ir_pkg;

    typedef enum logic {
        S_OPC,
        S_OPR
    } ir_state_e;

    // Length field lives in the low bits of the opcode byte.
    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned LEN_W   = 2;

    // NOP opcode, also the value outputs take after flush/reset.
    localparam int unsigned NOP_OPC = 0;

endpackage

// File: rtl/ir_len_decode.sv
// Combinational length-field decode of an opcode byte; clamps or traps lengths beyond MAX_OPS.
// IR_ILLEGAL_TRAP_EN selects trap (illegal one-byte instruction) instead of clamping.
module ir_len_decode
    import ir_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_OPS = 2
) (
    input  logic [DATA_W-1:0] opc_byte,
    output logic [LEN_W-1:0]  len,
    output logic              illegal,
    output logic              zero_len
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_OPS);

    logic [LEN_W-1:0] raw;
    logic             unused_hi;

    assign raw       = opc_byte[LEN_LSB +: LEN_W];
    assign unused_hi = ^opc_byte[DATA_W-1:LEN_W];

    always_comb begin
`ifdef IR_ILLEGAL_TRAP_EN
        illegal = (raw > MAX_LEN);
        len     = illegal ? '0 : raw;
`else
        illegal = 1'b0;
        len     = (raw > MAX_LEN) ? MAX_LEN : raw;
`endif
        zero_len = (len == '0);
    end

endmodule

// File: rtl/ir_assembler.sv
// Assembles opcode + 0..MAX_OPS operand bytes from busC into a one-entry output register.
// Build option: IR_ILLEGAL_TRAP_EN (see ir_len_decode).
module ir_assembler
    import ir_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OPC_W   = 5,
    parameter int unsigned MAX_OPS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         bus_data,
    input  logic                      bus_valid,
    output logic                      bus_ready,
    output logic [OPC_W-1:0]          opcode,
    output logic [MAX_OPS*DATA_W-1:0] operands,
    output logic [1:0]                op_count,
    output logic                      illegal,
    output logic                      instr_valid,
    input  logic                      instr_ready
);

    localparam int unsigned OPS_W = MAX_OPS * DATA_W;

    ir_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [OPC_W-1:0]  stg_opc_q, stg_opc_d;
    logic [1:0]        stg_len_q, stg_len_d;
    logic [OPS_W-1:0]  stg_ops_q, stg_ops_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [OPS_W-1:0]  operands_q, operands_d;
    logic [1:0]        op_count_q, op_count_d;
    logic              illegal_q, illegal_d;
    logic              valid_q, valid_d;

    logic [1:0]        dec_len;
    logic              dec_illegal, dec_zero;
    logic              completing, xfer;
    logic [OPS_W-1:0]  ops_ins;

    ir_len_decode #(
        .DATA_W  (DATA_W),
        .MAX_OPS (MAX_OPS)
    ) u_len_decode (
        .opc_byte (bus_data),
        .len      (dec_len),
        .illegal  (dec_illegal),
        .zero_len (dec_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_OPC;
            cnt_q      <= '0;
            stg_opc_q  <= '0;
            stg_len_q  <= '0;
            stg_ops_q  <= '0;
            opcode_q   <= OPC_W'(NOP_OPC);
            operands_q <= '0;
            op_count_q <= '0;
            illegal_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stg_opc_q  <= stg_opc_d;
            stg_len_q  <= stg_len_d;
            stg_ops_q  <= stg_ops_d;
            opcode_q   <= opcode_d;
            operands_q <= operands_d;
            op_count_q <= op_count_d;
            illegal_q  <= illegal_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stg_opc_d  = stg_opc_q;
        stg_len_d  = stg_len_q;
        stg_ops_d  = stg_ops_q;
        opcode_d   = opcode_q;
        operands_d = operands_q;
        op_count_d = op_count_q;
        illegal_d  = illegal_q;
        valid_d    = valid_q;

        ops_ins = stg_ops_q;
        for (int unsigned k = 0; k < MAX_OPS; k++) begin
            if (2'(k) == cnt_q) ops_ins[k*DATA_W +: DATA_W] = bus_data;
        end

        if (valid_q && instr_ready) valid_d = 1'b0;

        if (flush) begin
            state_d    = S_OPC;
            cnt_d      = '0;
            stg_opc_d  = '0;
            stg_len_d  = '0;
            stg_ops_d  = '0;
            opcode_d   = OPC_W'(NOP_OPC);
            operands_d = '0;
            op_count_d = '0;
            illegal_d  = 1'b0;
            valid_d    = 1'b0;
        end else if (xfer) begin
            unique case (state_q)
                S_OPC: begin
                    stg_opc_d = bus_data[DATA_W-1 -: OPC_W];
                    stg_len_d = dec_len;
                    stg_ops_d = '0;
                    cnt_d     = '0;
                    if (dec_zero) begin
                        opcode_d   = bus_data[DATA_W-1 -: OPC_W];
                        operands_d = '0;
                        op_count_d = '0;
                        illegal_d  = dec_illegal;
                        valid_d    = 1'b1;
                    end else begin
                        state_d = S_OPR;
                    end
                end
                S_OPR: begin
                    stg_ops_d = ops_ins;
                    cnt_d     = cnt_q + 2'd1;
                    if (completing) begin
                        opcode_d   = stg_opc_q;
                        operands_d = ops_ins;
                        op_count_d = stg_len_q;
                        illegal_d  = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = S_OPC;
                        cnt_d      = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only a completing byte waits for room in the output register.
    always_comb begin
        completing = (state_q == S_OPC) ? dec_zero : (cnt_q == stg_len_q - 2'd1);
        bus_ready  = !flush && (!completing || !valid_q || instr_ready);
        xfer       = bus_valid && bus_ready;
    end

    assign opcode      = opcode_q;
    assign operands    = operands_q;
    assign op_count    = op_count_q;
    assign illegal     = illegal_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_ir_assembler.sv
// Self-checking bench for ir_assembler: byte-queue reference model plus directed literal checks.
module tb_ir_assembler;

    localparam int DATA_W  = 8;
    localparam int OPC_W   = 5;
    localparam int MAX_OPS = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [DATA_W-1:0]         bus_data;
    logic                      bus_valid;
    logic                      bus_ready;
    logic [OPC_W-1:0]          opcode;
    logic [MAX_OPS*DATA_W-1:0] operands;
    logic [1:0]                op_count;
    logic                      illegal;
    logic                      instr_valid;
    logic                      instr_ready;

    ir_assembler #(
        .DATA_W  (DATA_W),
        .OPC_W   (OPC_W),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .opcode      (opcode),
        .operands    (operands),
        .op_count    (op_count),
        .illegal     (illegal),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic rdy_seen;

    // Reference model: bytes of the partial instruction, plus the held instruction.
    logic [DATA_W-1:0]         pend[$];
    logic                      m_valid;
    logic [OPC_W-1:0]          m_opc;
    logic [MAX_OPS*DATA_W-1:0] m_ops;
    logic [1:0]                m_cnt;
    logic                      m_ill;
    bit                        m_zeroed;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic int need_ops(input logic [DATA_W-1:0] b, output bit ill);
        int raw;
        raw = int'(b[1:0]);
        ill = 1'b0;
`ifdef IR_ILLEGAL_TRAP_EN
        if (raw > MAX_OPS) begin
            ill = 1'b1;
            return 0;
        end
        return raw;
`else
        return (raw > MAX_OPS) ? MAX_OPS : raw;
`endif
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_valid  = 1'b0;
        m_opc    = '0;
        m_ops    = '0;
        m_cnt    = '0;
        m_ill    = 1'b0;
        m_zeroed = 1'b1;
    endfunction

    function automatic logic model_ready();
        bit ill;
        int n;
        bit comp;
        if (flush) return 1'b0;
        if (pend.size() == 0) begin
            n    = need_ops(bus_data, ill);
            comp = (n == 0);
        end else begin
            n    = need_ops(pend[0], ill);
            comp = (pend.size() == n);
        end
        return !comp || !m_valid || instr_ready;
    endfunction

    function automatic void model_step(input logic rdy);
        bit ill;
        int n;
        bit done;
        logic [DATA_W-1:0] head;
        done = 1'b0;
        if (flush) begin
            model_reset();
            return;
        end
        if (bus_valid && rdy) begin
            pend.push_back(bus_data);
            head = pend[0];
            n    = need_ops(head, ill);
            if (pend.size() == n + 1) begin
                m_opc = head[DATA_W-1 -: OPC_W];
                m_ops = '0;
                for (int i = 1; i <= n; i++) m_ops[(i-1)*DATA_W +: DATA_W] = pend[i];
                m_cnt = 2'(n);
                m_ill = ill;
                done  = 1'b1;
                pend.delete();
            end
        end
        if (done) begin
            m_valid  = 1'b1;
            m_zeroed = 1'b0;
        end else if (m_valid && instr_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic compare(input logic exp_rdy);
        chk("bus_ready", 32'(bus_ready), 32'(exp_rdy));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid || m_zeroed) begin
            chk("opcode", 32'(opcode), 32'(m_opc));
            chk("operands", 32'(operands), 32'(m_ops));
            chk("op_count", 32'(op_count), 32'(m_cnt));
            chk("illegal", 32'(illegal), 32'(m_ill));
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
        logic exp_rdy;
        @(negedge clk);
        bus_valid   = v;
        bus_data    = d;
        instr_ready = r;
        flush       = f;
        #1;
        rdy_seen = bus_ready;
        exp_rdy  = model_ready();
        compare(exp_rdy);
        @(posedge clk);
        model_step(exp_rdy);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; bus_valid = 1'b0; bus_data = '0; instr_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_opcode", 32'(opcode), 0);
        chk("rst_operands", 32'(operands), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(bus_ready), 1);

        // Zero-operand instruction, valid for exactly one cycle.
        cycle(1'b1, 8'h28, 1'b1, 1'b0);
        #1;
        chk("t1_opcode", 32'(opcode), 5);
        chk("t1_op_count", 32'(op_count), 0);
        chk("t1_valid", 32'(instr_valid), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        chk("t1_valid_drop", 32'(instr_valid), 0);

        // Two-operand instruction.
        cycle(1'b1, 8'h4A, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h22, 1'b1, 1'b0);
        #1;
        chk("t2_opcode", 32'(opcode), 9);
        chk("t2_operands", 32'(operands), 32'h2211);
        chk("t2_op_count", 32'(op_count), 2);

        // Backpressure: opcode absorbed, completing operand stalls.
        cycle(1'b1, 8'h49, 1'b0, 1'b0);
        chk("bp_opc_ready", 32'(rdy_seen), 1);
        #1;
        chk("bp_hold_operands", 32'(operands), 32'h2211);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        chk("bp_stall", 32'(rdy_seen), 0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        chk("bp_release", 32'(rdy_seen), 1);
        #1;
        chk("bp_no_bubble", 32'(instr_valid), 1);
        chk("bp_operands", 32'(operands), 32'h0033);
        chk("bp_op_count", 32'(op_count), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush mid-instruction.
        cycle(1'b1, 8'h4A, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h28, 1'b1, 1'b1);
        chk("flush_ready", 32'(rdy_seen), 0);
        #1;
        chk("flush_valid", 32'(instr_valid), 0);
        chk("flush_opcode", 32'(opcode), 0);
        chk("flush_operands", 32'(operands), 0);
        cycle(1'b1, 8'h28, 1'b1, 1'b0);
        #1;
        chk("post_flush_opcode", 32'(opcode), 5);
        chk("post_flush_operands", 32'(operands), 0);
        chk("post_flush_valid", 32'(instr_valid), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Length field beyond MAX_OPS.
        cycle(1'b1, 8'h4B, 1'b1, 1'b0);
`ifdef IR_ILLEGAL_TRAP_EN
        #1;
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_op_count", 32'(op_count), 0);
        chk("ill_valid", 32'(instr_valid), 1);
        cycle(1'b1, 8'h28, 1'b1, 1'b0);
        #1;
        chk("ill_next_opcode", 32'(opcode), 5);
`else
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        cycle(1'b1, 8'h66, 1'b1, 1'b0);
        #1;
        chk("clamp_opcode", 32'(opcode), 9);
        chk("clamp_operands", 32'(operands), 32'h6655);
        chk("clamp_op_count", 32'(op_count), 2);
        chk("clamp_illegal", 32'(illegal), 0);
`endif
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 4) > 1),
                  ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset mid-operand.
        cycle(1'b1, 8'h28, 1'b0, 1'b0);
        cycle(1'b1, 8'h4A, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        bus_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 0);
        chk("arst_opcode", 32'(opcode), 0);
        chk("arst_operands", 32'(operands), 0);
        chk("arst_op_count", 32'(op_count), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        chk("arst_release_ready", 32'(bus_ready), 1);
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 1) == 1), 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ir_assembler.md
# ir_assembler

Parametrised instruction register that assembles variable-length instructions from the 8-bit instruction bus (busC). It accepts one opcode byte plus 0..MAX_OPS operand bytes over a valid/ready handshake, then presents the opcode and operands to the control unit through a one-entry output register with its own handshake. A synchronous flush discards any partial instruction and zeroes the outputs. It sits between the memory/bus interface and the control-unit decoder.

## Interface
- DATA_W, 8: bus and byte width; must satisfy DATA_W >= OPC_W + 2.
- OPC_W, 5: opcode width; opcode = byte[DATA_W-1 : DATA_W-OPC_W].
- MAX_OPS, 2: maximum operand bytes per instruction, range 0..3.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear; has priority over all other inputs.
- bus_data  in  DATA_W  instruction byte from busC.
- bus_valid  in  1  bus_data is valid.
- bus_ready  out  1  assembler accepts bus_data this cycle.
- opcode  out  OPC_W  opcode of the held instruction.
- operands  out  MAX_OPS*DATA_W  operand bytes; operand k at [k*DATA_W +: DATA_W]; unused slots are 0.
- op_count  out  2  number of valid operands.
- illegal  out  1  held instruction has an illegal length field.
- instr_valid  out  1  output register holds an instruction.
- instr_ready  in  1  control unit consumes the instruction.

## Operation
- Byte transfer occurs when bus_valid && bus_ready. Output transfer occurs when instr_valid && instr_ready.
- Length field: len = opcode byte[1:0].
- States:
  - S_OPC: waiting for an opcode byte. On transfer, latch opcode and len into staging and clear the staging operands. If len == 0, the instruction completes; stay in S_OPC. Otherwise go to S_OPR with cnt = 0.
  - S_OPR: each transferred byte is written to staging operand[cnt] and cnt increments. The byte with cnt == len-1 completes the instruction; return to S_OPC.
- Completing byte: the instruction is copied into the output register and instr_valid is set.
- bus_ready:
  - For a non-completing byte, bus_ready = 1.
  - For a potentially completing byte (S_OPC with len==0 on bus_data, or S_OPR with cnt==len-1), bus_ready = !instr_valid || instr_ready.
  - bus_ready depends combinationally on bus_data only in S_OPC.
- Simultaneous output consume and completing byte: the output register is overwritten with the new instruction and instr_valid stays 1. No bubble.
- Consume with no completion: instr_valid goes to 0. The outputs keep their last values (don't-care).
- flush: state goes to S_OPC, cnt goes to 0, staging is cleared. In the output register, instr_valid, opcode, operands, op_count and illegal all go to 0. Any byte offered in the flush cycle is not accepted, so bus_ready = 0 while flush = 1.
- Reset mid-instruction: behaves identically to flush, but asynchronously.

## Timing
- Reset values: opcode 0, operands 0, op_count 0, illegal 0, instr_valid 0. bus_ready is 1 after rst deasserts (S_OPC, output empty).
- Latency: instr_valid rises on the clock edge that accepts the last byte. The instruction is visible the cycle after that byte's transfer.
- Throughput: one byte per cycle. Zero-operand instructions complete back-to-back every cycle while instr_ready = 1.
- Backpressure: with instr_valid=1 and instr_ready=0, the assembler stalls only on a completing byte. Earlier operand bytes of the next instruction are still absorbed into staging.

## Configuration
- IR_ILLEGAL_TRAP_EN defined: when len > MAX_OPS, the opcode byte completes alone as a one-byte instruction with illegal=1 and op_count=0. No operand bytes are consumed.
- IR_ILLEGAL_TRAP_EN undefined: len is clamped to MAX_OPS and the clamped number of operands is collected. The illegal output is tied to 0.

## Structure
- Package ir_pkg contains:
  - the state enum (S_OPC, S_OPR);
  - the length-field position constants;
  - the NOP opcode constant (all zeros, the flush value).
- Sub-module ir_len_decode is purely combinational. It takes the opcode byte and MAX_OPS and produces the effective len, illegal and a zero-length flag. It is shared with the future decoder.

## Test plan
- Reset, then send byte 0x28 (opcode 5, len 0) with instr_ready=1. Next cycle: opcode=5, op_count=0, instr_valid=1 for exactly one cycle.
- Send 0x4A, 0x11, 0x22 (opcode 9, len 2) on consecutive cycles. After the third transfer: opcode=9, operands=0x2211, op_count=2.
- Hold instr_ready=0 with one instruction held, then send 0x49, 0x33 (len 1). 0x49 is accepted; bus_ready=0 on 0x33 until instr_ready=1. In the cycle instr_ready rises, 0x33 is accepted and the new instruction replaces the old with no bubble.
- Assert flush after 0x4A, 0x11. Next cycle: instr_valid=0, opcode=0. Then send 0x28: a clean one-byte instruction results.
- Send 0x4B (len 3, MAX_OPS=2). With IR_ILLEGAL_TRAP_EN: illegal=1, op_count=0, the next byte is treated as an opcode. Without it: two operand bytes are collected, illegal=0.
- Assert rst asynchronously mid-operand. All outputs go to 0 immediately; bus_ready=1 after release.
